// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

    // Arbiter phases: waiting for a requester, emitting the channel header,
    // streaming payload beats of the granted requester.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        PASS   = 2'd2
    } state_e;

    // Width of a port index; a single bit even for degenerate port counts.
    function automatic int id_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arb.sv
// Combinational rotate-priority pick: the first requester strictly after the
// previously served index (wrapping) wins. Holds no state of its own.
module uart_rr_arb
    import uart_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int ID_W  = id_width(PORTS)
) (
    input  logic [PORTS-1:0] req_i,
    input  logic [ID_W-1:0]  last_i,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             gnt_valid_o
);

    // Scan PORTS candidates starting one past last_i; the first hit wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        for (int k = 1; k <= PORTS; k++) begin
            int idx;
            idx = (int'(last_i) + k) % PORTS;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_id_o    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one byte stream (feeding uart_tx) between several AXI4-Stream
// requesters. Round-robin grant, grant held until tlast, optional channel-ID
// header byte per packet, forced release after PKT_MAX payload beats. The
// output side is a single registered beat.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int                    PORTS       = 4,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    HEADER_EN   = 1,
    parameter logic [DATA_WIDTH-1:0] HEADER_BASE = 8'hF0,
    parameter int                    PKT_MAX     = 256,
    localparam int                   ID_W        = id_width(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [ID_W-1:0]             grant_id,
    output logic                        active
);

    // Counter wide enough to hold PKT_MAX itself, so it never wraps.
    localparam int             BCW       = $clog2(PKT_MAX + 1);
    localparam logic [BCW-1:0] PKT_MAX_C = BCW'(PKT_MAX);

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         grant_id_q, grant_id_d;
    logic [ID_W-1:0]         last_q, last_d;
    logic [BCW-1:0]          beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d;

    logic                    accept_new;
    logic                    handshake;
    logic [DATA_WIDTH-1:0]   sel_tdata;
    logic                    sel_tvalid;
    logic                    sel_tlast;
    logic [BCW-1:0]          beat_inc;
    logic [ID_W-1:0]         pick_id;
    logic                    pick_valid;

    uart_rr_arb #(
        .PORTS (PORTS),
        .ID_W  (ID_W)
    ) u_rr_arb (
        .req_i       (s_axis_tvalid),
        .last_i      (last_q),
        .gnt_id_o    (pick_id),
        .gnt_valid_o (pick_valid)
    );

    // The output register can take a new beat when empty or being drained now.
    assign accept_new = !tvalid_q || m_axis_tready;
    assign sel_tdata  = s_axis_tdata[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    assign sel_tvalid = s_axis_tvalid[grant_id_q];
    assign sel_tlast  = s_axis_tlast[grant_id_q];
    assign handshake  = (state_q == PASS) && sel_tvalid && accept_new;
    assign beat_inc   = beat_cnt_q + 1'b1;

    // Only the granted port sees ready, and only while passing payload.
    always_comb begin
        s_axis_tready = '0;
        if (state_q == PASS) begin
            s_axis_tready[grant_id_q] = accept_new;
        end
    end

    // Next-state logic: grant in IDLE, header load, payload load and release.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;

        // A held beat taken by the sink empties the register unless refilled below.
        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_id_d = pick_id;
                    beat_cnt_d = '0;
                    state_d    = (HEADER_EN != 0) ? HEADER : PASS;
                end
            end
            HEADER: begin
                if (accept_new) begin
                    tdata_d  = HEADER_BASE + DATA_WIDTH'(grant_id_q);
                    tvalid_d = 1'b1;
                    state_d  = PASS;
                end
            end
            PASS: begin
                if (handshake) begin
                    tdata_d    = sel_tdata;
                    tvalid_d   = 1'b1;
                    beat_cnt_d = beat_inc;
                    // The PKT_MAX-th beat closes the grant as if it carried tlast.
                    if (sel_tlast || (beat_inc == PKT_MAX_C)) begin
                        state_d = IDLE;
                        last_d  = grant_id_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output register with synchronous reset; reset drops any held beat.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_q     <= ID_W'(PORTS - 1);
            beat_cnt_q <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign grant_id      = grant_id_q;
    assign active        = (state_q != IDLE);

endmodule
